// File: rtl/item_store_pkg.sv
// Shared types and default sizes for the item_store vending datapath.
`timescale 1ns/1ps
package item_store_pkg;
    localparam int MAX_ITEMS_DEF   = 1024;
    localparam int COUNT_WIDTH_DEF = 8;
    localparam int PRICE_WIDTH_DEF = 16;
    localparam int NUM_PORTS_DEF   = 2;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic [COUNT_WIDTH_DEF-1:0] dispensed;
        logic [COUNT_WIDTH_DEF-1:0] count;
        logic [PRICE_WIDTH_DEF-1:0] price;
    } item_rec_t;
endpackage

// File: rtl/item_store_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
`timescale 1ns/1ps
module rr_arbiter
    import item_store_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        gnt_idx,
    output logic                 gnt_any
);
    logic [PW-1:0] ptr;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (en && !gnt_any && req[(int'(ptr) + i) % NUM_PORTS]) begin
                gnt[(int'(ptr) + i) % NUM_PORTS] = 1'b1;
                gnt_idx = PW'((int'(ptr) + i) % NUM_PORTS);
                gnt_any = 1'b1;
            end
        end
    end

    // Pointer starts at the last channel so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= PW'(NUM_PORTS - 1);
        else if (gnt_any)
            ptr <= gnt_idx;
    end
endmodule

// File: rtl/item_store.sv
// Per-item {dispensed, count, price} store with config port, arbitrated
// dispense read-modify-write pipeline and a registered display read port.
`timescale 1ns/1ps
module item_store
    import item_store_pkg::*;
#(
    parameter int MAX_ITEMS   = MAX_ITEMS_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
    parameter int PRICE_WIDTH = PRICE_WIDTH_DEF,
    parameter int NUM_PORTS   = NUM_PORTS_DEF,
    localparam int AW = $clog2(MAX_ITEMS),
    localparam int DW = 2*COUNT_WIDTH + PRICE_WIDTH,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    output logic                    cfg_ready,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [COUNT_WIDTH-1:0]  cfg_count,
    input  logic [PRICE_WIDTH-1:0]  cfg_price,
    input  logic [AW-1:0]           rd_addr,
    output logic [DW-1:0]           rd_data,
    input  logic [NUM_PORTS-1:0]    disp_req,
    input  logic [NUM_PORTS*AW-1:0] disp_addr,
    output logic [NUM_PORTS-1:0]    disp_gnt,
    output logic [NUM_PORTS-1:0]    disp_valid,
    output logic                    disp_ok
);
    typedef struct packed {
        logic [COUNT_WIDTH-1:0] dispensed;
        logic [COUNT_WIDTH-1:0] count;
        logic [PRICE_WIDTH-1:0] price;
    } rec_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    rec_t          mem [MAX_ITEMS];
    state_t        state;
    logic [AW-1:0] sweep;

    logic          arb_en;
    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [AW-1:0] gnt_addr;

    logic          vld_p1;
    logic [AW-1:0] addr_p1;
    logic [PW-1:0] chan_p1;
    rec_t          mem_q_p1;
    rec_t          cur_p1;
    rec_t          nxt_p1;
    logic          ok_p1;

    logic          wr_vld_p2;
    logic [AW-1:0] wr_addr_p2;
    rec_t          wr_rec_p2;

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    rec_t          mem_wd;

    // Config has priority: a pending write stalls new grants so the pipe drains.
    assign arb_en   = (state == RUN) && !cfg_we;
    assign gnt_addr = disp_addr[int'(gnt_idx)*AW +: AW];

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_en),
        .req     (disp_req),
        .gnt     (disp_gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // cfg_ready is registered: next cycle is RUN and nothing granted now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            sweep     <= '0;
            cfg_ready <= 1'b0;
        end else if (state == INIT) begin
            if (sweep == AW'(MAX_ITEMS - 1)) begin
                state     <= RUN;
                cfg_ready <= 1'b1;
            end else begin
                sweep <= sweep + 1'b1;
            end
        end else begin
            cfg_ready <= !gnt_any;
        end
    end

    // ---- p0 -> p1: memory read issued in the grant cycle
    always_ff @(posedge clk) begin
        addr_p1    <= gnt_addr;
        chan_p1    <= gnt_idx;
        mem_q_p1   <= mem[gnt_addr];
        wr_addr_p2 <= addr_p1;
        wr_rec_p2  <= nxt_p1;
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    // ---- p1: evaluate, forwarding the write that landed on the read edge
    always_comb begin
        cur_p1 = (wr_vld_p2 && (wr_addr_p2 == addr_p1)) ? wr_rec_p2 : mem_q_p1;
        ok_p1  = (cur_p1.count != '0);
        nxt_p1 = cur_p1;
        nxt_p1.count     = cur_p1.count - 1'b1;
        nxt_p1.dispensed = sat_inc(cur_p1.dispensed);
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = addr_p1;
        mem_wd = nxt_p1;
        if (state == INIT) begin
            mem_we = 1'b1;
            mem_wa = sweep;
            mem_wd = '0;
        end else if (cfg_we && cfg_ready) begin
            mem_we           = 1'b1;
            mem_wa           = cfg_addr;
            mem_wd.dispensed = '0;
            mem_wd.count     = cfg_count;
            mem_wd.price     = cfg_price;
        end else if (vld_p1 && ok_p1) begin
            mem_we = 1'b1;
        end
    end

    // ---- p1 -> p2: result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wr_vld_p2  <= 1'b0;
            disp_valid <= '0;
            disp_ok    <= 1'b0;
        end else begin
            vld_p1     <= gnt_any;
            wr_vld_p2  <= vld_p1 && ok_p1;
            disp_valid <= vld_p1 ? (NUM_PORTS'(1) << chan_p1) : '0;
            disp_ok    <= vld_p1 && ok_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end
endmodule
